// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two valid/ready requesters.
// Accepts one op at a time; the result is registered and held until the winning port consumes it.

module alu (
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] out,
    output logic        zero
);
    always_comb begin
        out = 32'd0;
        case (op)
            3'b010:  out = a + b;
            3'b110:  out = a - b;
            3'b000:  out = a & b;
            3'b001:  out = a | b;
            3'b111:  out = {31'd0, $signed(a) < $signed(b)};
            default: out = 32'd0;
        endcase
    end

    assign zero = (out == 32'd0);
endmodule

module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid0,
    input  logic             req_valid1,
    output logic             req_ready0,
    output logic             req_ready1,
    input  logic [OPW-1:0]   req_op0,
    input  logic [OPW-1:0]   req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    output logic             resp_valid0,
    output logic             resp_valid1,
    input  logic             resp_ready0,
    input  logic             resp_ready1,
    output logic [WIDTH-1:0] resp_out,
    output logic             resp_zero,
    output logic             resp_err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             gnt_q, gnt_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic             win;
    logic             any_valid;
    logic             illegal;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;

    // Both valid: prio decides; otherwise the sole valid port wins.
    assign win       = (req_valid0 && req_valid1) ? prio_q : req_valid1;
    assign any_valid = req_valid0 || req_valid1;
    assign illegal   = (op_q == 3'b011) || (op_q == 3'b100) || (op_q == 3'b101);
    assign alu_op    = illegal ? 3'b000 : op_q;

    alu u_alu (
        .op   (alu_op),
        .a    (a_q),
        .b    (b_q),
        .out  (alu_out),
        .zero (alu_zero)
    );

    assign req_ready0  = (state_q == IDLE) && any_valid && !win;
    assign req_ready1  = (state_q == IDLE) && any_valid && win;
    assign resp_valid0 = (state_q == RESP) && !gnt_q;
    assign resp_valid1 = (state_q == RESP) && gnt_q;
    assign resp_out    = out_q;
    assign resp_zero   = zero_q;
    assign resp_err    = err_q;
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    gnt_d   = win;
                    op_d    = win ? req_op1 : req_op0;
                    a_d     = win ? req_a1  : req_a0;
                    b_d     = win ? req_b1  : req_b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                out_d   = illegal ? '0 : alu_out;
                zero_d  = illegal ? 1'b1 : alu_zero;
                err_d   = illegal;
                state_d = RESP;
            end
            RESP: begin
                if (gnt_q ? resp_ready1 : resp_ready0) begin
                    prio_d  = !gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            gnt_q   <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: handshake timing, results, fairness, backpressure, illegal ops, reset.

module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid0 = 1'b0, req_valid1 = 1'b0;
    logic        req_ready0, req_ready1;
    logic [2:0]  req_op0 = '0, req_op1 = '0;
    logic [31:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
    logic        resp_valid0, resp_valid1;
    logic        resp_ready0 = 1'b0, resp_ready1 = 1'b0;
    logic [31:0] resp_out;
    logic        resp_zero, resp_err, busy;

    int checks = 0;
    int errors = 0;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid0(req_valid0), .req_valid1(req_valid1),
        .req_ready0(req_ready0), .req_ready1(req_ready1),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_a1(req_a1),
        .req_b0(req_b0), .req_b1(req_b1),
        .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
        .resp_ready0(resp_ready0), .resp_ready1(resp_ready1),
        .resp_out(resp_out), .resp_zero(resp_zero), .resp_err(resp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic consume(input int port);
        if (port == 0) resp_ready0 = 1'b1; else resp_ready1 = 1'b1;
        @(negedge clk);
        resp_ready0 = 1'b0;
        resp_ready1 = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        checks++;
        if ({req_ready0, req_ready1, resp_valid0, resp_valid1} !== 4'b0000) begin
            errors++; $display("FAIL reset_handshake: got %b exp 0000", {req_ready0, req_ready1, resp_valid0, resp_valid1});
        end
        checks++;
        if ({busy, resp_err, resp_zero} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b exp 000", {busy, resp_err, resp_zero});
        end
        checks++;
        if (resp_out !== 32'd0) begin
            errors++; $display("FAIL reset_out: got %h exp 00000000", resp_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single_add;
        req_op0 = 3'b010; req_a0 = 32'd5; req_b0 = 32'd7; req_valid0 = 1'b1;
        #1;
        checks++;
        if ({req_ready0, req_ready1} !== 2'b10) begin
            errors++; $display("FAIL add_ready: got %b exp 10", {req_ready0, req_ready1});
        end
        @(negedge clk);
        req_valid0 = 1'b0;
        #1;
        checks++;
        if ({busy, resp_valid0} !== 2'b10) begin
            errors++; $display("FAIL add_exec: got busy/valid %b exp 10", {busy, resp_valid0});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({resp_valid0, resp_valid1} !== 2'b10) begin
            errors++; $display("FAIL add_resp_valid: got %b exp 10", {resp_valid0, resp_valid1});
        end
        checks++;
        if ({resp_out, resp_zero, resp_err} !== {32'd12, 2'b00}) begin
            errors++; $display("FAIL add_result: got %h z%b e%b exp 0000000c z0 e0", resp_out, resp_zero, resp_err);
        end
        consume(0);
        checks++;
        if ({busy, resp_valid0} !== 2'b00) begin
            errors++; $display("FAIL add_consumed: got busy/valid %b exp 00", {busy, resp_valid0});
        end
    endtask

    task automatic test_sub_slt;
        req_op1 = 3'b110; req_a1 = 32'h1234; req_b1 = 32'h1234; req_valid1 = 1'b1;
        #1;
        checks++;
        if ({req_ready0, req_ready1} !== 2'b01) begin
            errors++; $display("FAIL sub_ready: got %b exp 01", {req_ready0, req_ready1});
        end
        @(negedge clk); req_valid1 = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({resp_valid1, resp_out, resp_zero} !== {1'b1, 32'd0, 1'b1}) begin
            errors++; $display("FAIL sub_result: got v%b %h z%b exp v1 00000000 z1", resp_valid1, resp_out, resp_zero);
        end
        consume(1);
        req_op1 = 3'b111; req_a1 = 32'hFFFF_FFFF; req_b1 = 32'd1; req_valid1 = 1'b1;
        @(negedge clk); req_valid1 = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({resp_valid1, resp_out, resp_zero} !== {1'b1, 32'd1, 1'b0}) begin
            errors++; $display("FAIL slt_result: got v%b %h z%b exp v1 00000001 z0", resp_valid1, resp_out, resp_zero);
        end
        consume(1);
    endtask

    task automatic test_contention;
        logic [31:0] exp_out;
        req_op0 = 3'b001; req_a0 = 32'hF0; req_b0 = 32'h0F;
        req_op1 = 3'b000; req_a1 = 32'hF0; req_b1 = 32'h0F;
        req_valid0 = 1'b1; req_valid1 = 1'b1;
        resp_ready0 = 1'b1; resp_ready1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({req_ready0, req_ready1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL contention_grant%0d: got %b exp %b", i, {req_ready0, req_ready1}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            @(negedge clk);
            @(negedge clk);
            #1;
            exp_out = (i % 2 == 0) ? 32'hFF : 32'h0;
            checks++;
            if ({resp_valid0, resp_valid1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL contention_valid%0d: got %b", i, {resp_valid0, resp_valid1});
            end
            checks++;
            if ({resp_out, resp_zero} !== {exp_out, (i % 2 == 1)}) begin
                errors++; $display("FAIL contention_result%0d: got %h z%b exp %h", i, resp_out, resp_zero, exp_out);
            end
            @(negedge clk);
        end
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        resp_ready0 = 1'b0; resp_ready1 = 1'b0;
        #1;
    endtask

    task automatic test_backpressure;
        req_op0 = 3'b010; req_a0 = 32'hFFFF_FFFF; req_b0 = 32'd1; req_valid0 = 1'b1;
        req_op1 = 3'b010; req_a1 = 32'd2; req_b1 = 32'd3; req_valid1 = 1'b1;
        #1;
        checks++;
        if ({req_ready0, req_ready1} !== 2'b10) begin
            errors++; $display("FAIL bp_grant: got %b exp 10", {req_ready0, req_ready1});
        end
        @(negedge clk); req_valid0 = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({resp_valid0, resp_out, resp_zero, req_ready1} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin
                errors++; $display("FAIL bp_hold%0d: got v%b %h z%b rdy1 %b exp v1 00000000 z1 rdy1 0", i, resp_valid0, resp_out, resp_zero, req_ready1);
            end
            @(negedge clk);
        end
        consume(0);
        checks++;
        if ({resp_valid0, req_ready1} !== 2'b01) begin
            errors++; $display("FAIL bp_next_grant: got valid0/ready1 %b exp 01", {resp_valid0, req_ready1});
        end
        @(negedge clk); req_valid1 = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({resp_valid1, resp_out} !== {1'b1, 32'd5}) begin
            errors++; $display("FAIL bp_port1_result: got v%b %h exp v1 00000005", resp_valid1, resp_out);
        end
        consume(1);
    endtask

    task automatic test_illegal;
        req_op1 = 3'b101; req_a1 = 32'd7; req_b1 = 32'd9; req_valid1 = 1'b1;
        @(negedge clk); req_valid1 = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({resp_valid1, resp_err, resp_out, resp_zero} !== {2'b11, 32'd0, 1'b1}) begin
            errors++; $display("FAIL illegal_result: got v%b e%b %h z%b exp v1 e1 00000000 z1", resp_valid1, resp_err, resp_out, resp_zero);
        end
        consume(1);
        req_op1 = 3'b010; req_a1 = 32'd1; req_b1 = 32'd1; req_valid1 = 1'b1;
        @(negedge clk); req_valid1 = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({resp_err, resp_out, resp_zero} !== {1'b0, 32'd2, 1'b0}) begin
            errors++; $display("FAIL illegal_clear: got e%b %h z%b exp e0 00000002 z0", resp_err, resp_out, resp_zero);
        end
        consume(1);
    endtask

    task automatic test_reset_mid;
        bit seen;
        req_op1 = 3'b010; req_a1 = 32'd8; req_b1 = 32'd8; req_valid1 = 1'b1;
        @(negedge clk); req_valid1 = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, resp_valid1, resp_err, resp_zero, resp_out} !== 36'd0) begin
            errors++; $display("FAIL rst_exec: got busy%b v%b e%b z%b %h exp all 0", busy, resp_valid1, resp_err, resp_zero, resp_out);
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (resp_valid0 || resp_valid1 || busy) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rst_exec_no_resp: got activity %b exp 0", seen);
        end
        // Completing a port-0 op leaves port 1 preferred, so the final grant proves prio was reset.
        req_op0 = 3'b010; req_a0 = 32'd3; req_b0 = 32'd4; req_valid0 = 1'b1;
        @(negedge clk); req_valid0 = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({resp_valid0, resp_out} !== {1'b1, 32'd7}) begin
            errors++; $display("FAIL rst_pre_op: got v%b %h exp v1 00000007", resp_valid0, resp_out);
        end
        consume(0);
        req_op0 = 3'b010; req_a0 = 32'd10; req_b0 = 32'd10; req_valid0 = 1'b1;
        @(negedge clk); req_valid0 = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({resp_valid0, resp_out} !== {1'b1, 32'd20}) begin
            errors++; $display("FAIL rst_resp_pre: got v%b %h exp v1 00000014", resp_valid0, resp_out);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, resp_valid0, resp_zero, resp_out} !== 35'd0) begin
            errors++; $display("FAIL rst_resp: got busy%b v%b z%b %h exp all 0", busy, resp_valid0, resp_zero, resp_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid0 = 1'b1; req_valid1 = 1'b1;
        #1;
        checks++;
        if ({req_ready0, req_ready1, resp_valid0} !== 3'b100) begin
            errors++; $display("FAIL rst_prio: got ready0/ready1/valid0 %b exp 100", {req_ready0, req_ready1, resp_valid0});
        end
        @(negedge clk); req_valid0 = 1'b0; req_valid1 = 1'b0;
        @(negedge clk); #1;
        consume(0);
    endtask

    initial begin
        test_reset;
        test_single_add;
        test_sub_slt;
        test_contention;
        test_backpressure;
        test_illegal;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 32-bit `alu` instance between two requesters (port 0, port 1), e.g. the execute stage and a multi-cycle address/compare unit.
- Accepts one operation at a time over valid/ready and arbitrates round-robin.
- Drives the shared ALU from registered operands and returns a registered result/zero/error response to the winning requester over its own valid/ready channel.
- Screens out opcodes the ALU does not decode.

Parameters:
- WIDTH, 32, operand/result width. Fixed at 32, matching the ALU.
- OPW, 3, ALU opcode width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid0 / req_valid1  in  1  requester has an operation
- req_ready0 / req_ready1  out  1  arbiter accepts that requester this cycle
- req_op0 / req_op1  in  3  ALU opcode: 010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT
- req_a0 / req_a1  in  32  operand A
- req_b0 / req_b1  in  32  operand B
- resp_valid0 / resp_valid1  out  1  result available for that requester
- resp_ready0 / resp_ready1  in  1  requester consumes the result
- resp_out  out  32  result, shared by both ports; meaningful only with that port's resp_valid
- resp_zero  out  1  result == 0
- resp_err  out  1  opcode was illegal (011, 100, 101)
- busy  out  1  FSM not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, prio=0 (port 0 preferred).
  - All req_ready*, resp_valid*, busy, resp_err = 0.
  - resp_out = 0, resp_zero = 0, op/operand registers cleared.
  - Reset mid-operation discards any in-flight op; no response is issued for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_readyN asserted combinationally only for the grant winner, only in IDLE.
  - Winner = sole valid requester. If both are valid, the port equal to prio wins.
  - On handshake (valid & ready): latch op/A/B and grant id, go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC (exactly 1 cycle):
  - Registered op/A/B drive the ALU.
  - Register out/zero into the resp_* registers and go to RESP.
  - Illegal op: the ALU is driven with op 000, and the stored result is forced to resp_out=0, resp_zero=1, resp_err=1.
- RESP:
  - resp_validN = 1 for the granted port only.
  - resp_out, resp_zero and resp_err are held stable until resp_readyN=1.
  - On consume: prio flips to the other port (even if the other port is idle), go to IDLE.
  - The response to a port persists indefinitely under backpressure; the other port is stalled meanwhile (no req_ready).
- Latency: accept at cycle t, resp_valid at t+2. Minimum issue interval is 3 cycles per op; a new accept is possible the cycle after consume.
- The opposite port's resp_ready is ignored. Requests may change while not accepted; only handshake-cycle values are captured.
- SLT is signed compare, as implemented by the ALU. Arithmetic wraps modulo 2^32; no overflow flag.
- busy = (state != IDLE).

Test Plan:
- Single ADD: port0, op=010, A=5, B=7 → req_ready0 high the same cycle; resp_valid0 two cycles later with resp_out=12, zero=0, err=0; resp_valid1 stays 0.
- SUB zero / SLT:
  - port1, op=110, A=B=0x1234 → resp_out=0, zero=1.
  - Then op=111, A=0xFFFFFFFF, B=1 → resp_out=1.
- Contention fairness: both ports hold valid continuously after reset.
  - Grants alternate 0,1,0,1 for 4 ops; each result matches its own operands.
  - Port0 op=001 on 0xF0/0x0F → 0xFF; port1 op=000 on 0xF0/0x0F → 0, zero=1.
- Backpressure: port0 ADD 0xFFFFFFFF+1 with resp_ready0 held low for 5 cycles.
  - resp_out=0 and zero=1 stay stable throughout.
  - req_ready1 stays 0 despite req_valid1.
  - Response consumed on the cycle resp_ready0 rises; port1 granted next cycle.
- Illegal op: port1 op=101 → resp_err=1, resp_out=0, zero=1; the next legal op clears err.
- Reset mid-op: assert rst_n=0 while in EXEC, then in RESP.
  - Outputs go to reset values immediately (async); no resp_valid after release.
  - prio=0: simultaneous requests afterwards grant port0 first.
